// File: rtl/cl_fpgarr_types.sv
// ============================================================================
// Package     : cl_fpgarr_types
// Description : Shared record/replay channel-width types and the fixed-slot
//               offset helper used by both the logging packer and replay unpacker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cl_fpgarr_types;

  localparam int RR_CHANNEL_WIDTH_BITS = 8;
  localparam int RR_MAX_CHANNELS       = 32;

  typedef bit [RR_CHANNEL_WIDTH_BITS-1:0] rr_chan_width_t;
  typedef rr_chan_width_t [RR_MAX_CHANNELS-1:0] rr_width_vec_t;

  // Sum of the widths of all channels below idx (the fixed unpacked slot offset).
  function automatic int rr_chan_offset(input rr_width_vec_t widths, input int idx);
    int off = 0;
    for (int j = 0; j < RR_MAX_CHANNELS; j++) begin
      if (j < idx) off += int'(widths[j]);
    end
    return off;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_replay_pipe_slice.sv
// ============================================================================
// Module      : rr_replay_pipe_slice
// Description : Generic valid/ready register slice, one beat deep, full throughput.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_replay_pipe_slice #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic                  r_active;
  logic                  r_full;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  w_load;

  // r_active keeps the slice closed to upstream while reset is held.
  assign o_ready = r_active && (!r_full || i_ready);
  assign w_load  = i_valid && o_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_active <= 1'b0;
      r_full   <= 1'b0;
      r_data   <= '0;
    end else begin
      r_active <= 1'b1;
      if (w_load) begin
        r_full <= 1'b1;
        r_data <= i_data;
      end else if (i_ready) begin
        r_full <= 1'b0;
      end
    end
  end

  assign o_valid = r_full;
  assign o_data  = r_data;

endmodule

`default_nettype wire

// File: rtl/rr_replay_bus_pack2unpack.sv
// ============================================================================
// Module      : rr_replay_bus_pack2unpack
// Description : Scatters densely packed trace payloads back to fixed channel slots.
//               Optional macro RR_UNPACK_LEN_CHECK_EN enables the sticky len_err check.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_replay_bus_pack2unpack
  import cl_fpgarr_types::*;
#(
  parameter int LOGB_CHANNEL_CNT = 4,
  parameter int LOGE_CHANNEL_CNT = 2,
  parameter bit [LOGB_CHANNEL_CNT-1:0][RR_CHANNEL_WIDTH_BITS-1:0] CHANNEL_WIDTHS =
    '{8'd12, 8'd4, 8'd16, 8'd8},
  localparam rr_width_vec_t c_WIDTHS_EXT = rr_width_vec_t'(CHANNEL_WIDTHS),
  localparam int FULL_WIDTH   = rr_chan_offset(c_WIDTHS_EXT, LOGB_CHANNEL_CNT),
  localparam int OFFSET_WIDTH = $clog2(FULL_WIDTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [FULL_WIDTH-1:0]       in_data,
  input  logic [OFFSET_WIDTH-1:0]     in_len,
  input  logic [LOGB_CHANNEL_CNT-1:0] in_logb_valid,
  input  logic [LOGE_CHANNEL_CNT-1:0] in_loge_valid,
  output logic                        in_ready,
  output logic                        out_valid,
  output logic [LOGB_CHANNEL_CNT-1:0] out_logb_valid,
  output logic [FULL_WIDTH-1:0]       out_logb_data,
  output logic [LOGE_CHANNEL_CNT-1:0] out_loge_valid,
  input  logic                        out_ready,
  output logic                        len_err
);

  typedef struct packed {
    logic [FULL_WIDTH-1:0]                         data;
    logic [LOGB_CHANNEL_CNT-1:0]                   logb_valid;
    logic [LOGE_CHANNEL_CNT-1:0]                   loge_valid;
    logic [LOGB_CHANNEL_CNT-1:0][OFFSET_WIDTH-1:0] pos;
  } s1_beat_t;

  typedef struct packed {
    logic [FULL_WIDTH-1:0]       data;
    logic [LOGB_CHANNEL_CNT-1:0] logb_valid;
    logic [LOGE_CHANNEL_CNT-1:0] loge_valid;
  } s2_beat_t;

  for (genvar i = 0; i < LOGB_CHANNEL_CNT; i++) begin : g_chk_width
    if (CHANNEL_WIDTHS[i] == '0) begin : g_zero
      $error("rr_replay_bus_pack2unpack: channel %0d has zero width", i);
    end
  end
  if (LOGB_CHANNEL_CNT > RR_MAX_CHANNELS) begin : g_too_many
    $error("rr_replay_bus_pack2unpack: too many logb channels");
  end
  if (FULL_WIDTH != rr_chan_offset(c_WIDTHS_EXT, RR_MAX_CHANNELS)) begin : g_bad_full
    $error("rr_replay_bus_pack2unpack: FULL_WIDTH does not match sum of widths");
  end

  logic [LOGB_CHANNEL_CNT-1:0][OFFSET_WIDTH-1:0] w_pos;
  logic [OFFSET_WIDTH-1:0]                       w_exp_len;
  s1_beat_t                                      w_s1_in;
  s1_beat_t                                      w_s1_out;
  logic                                          w_s1_valid;
  logic                                          w_s2_ready;
  s2_beat_t                                      w_s2_in;
  s2_beat_t                                      w_s2_out;
  wire  [FULL_WIDTH-1:0]                         w_scatter;

  // Packed source offset of each channel: running sum of the present widths below it.
  always_comb begin
    logic [OFFSET_WIDTH-1:0] w_acc;
    w_pos = '0;
    w_acc = '0;
    for (int i = 0; i < LOGB_CHANNEL_CNT; i++) begin
      w_pos[i] = w_acc;
      if (in_logb_valid[i]) w_acc = w_acc + OFFSET_WIDTH'(CHANNEL_WIDTHS[i]);
    end
    w_exp_len = w_acc;
  end

  assign w_s1_in = {in_data, in_logb_valid, in_loge_valid, w_pos};

  rr_replay_pipe_slice #(
    .DATA_WIDTH ($bits(s1_beat_t))
  ) u_s1 (
    .clk     (clk),
    .rst     (rst),
    .i_valid (in_valid),
    .o_ready (in_ready),
    .i_data  (w_s1_in),
    .o_valid (w_s1_valid),
    .i_ready (w_s2_ready),
    .o_data  (w_s1_out)
  );

  for (genvar i = 0; i < LOGB_CHANNEL_CNT; i++) begin : g_scatter
    localparam int c_OFF = rr_chan_offset(c_WIDTHS_EXT, i);
    localparam int c_W   = int'(CHANNEL_WIDTHS[i]);
    assign w_scatter[c_OFF +: c_W] = w_s1_out.logb_valid[i] ?
                                     c_W'(w_s1_out.data >> w_s1_out.pos[i]) : '0;
  end

  assign w_s2_in = {w_scatter, w_s1_out.logb_valid, w_s1_out.loge_valid};

  rr_replay_pipe_slice #(
    .DATA_WIDTH ($bits(s2_beat_t))
  ) u_s2 (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_s1_valid),
    .o_ready (w_s2_ready),
    .i_data  (w_s2_in),
    .o_valid (out_valid),
    .i_ready (out_ready),
    .o_data  (w_s2_out)
  );

  assign out_logb_data  = w_s2_out.data;
  assign out_logb_valid = w_s2_out.logb_valid;
  assign out_loge_valid = w_s2_out.loge_valid;

`ifdef RR_UNPACK_LEN_CHECK_EN
  logic r_len_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len_err <= 1'b0;
    end else if (in_valid && in_ready && (in_len != w_exp_len)) begin
      r_len_err <= 1'b1;
    end
  end

  assign len_err = r_len_err;
`else
  logic w_unused_len;
  assign w_unused_len = ^{in_len, w_exp_len};
  assign len_err      = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rr_replay_bus_pack2unpack.sv
// ============================================================================
// Module      : tb_rr_replay_bus_pack2unpack
// Description : Directed self-checking bench for the replay bus unpacker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rr_replay_bus_pack2unpack;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [39:0] in_data = '0;
  logic [5:0]  in_len = '0;
  logic [3:0]  in_logb_valid = '0;
  logic [1:0]  in_loge_valid = '0;
  logic        in_ready;
  logic        out_valid;
  logic [3:0]  out_logb_valid;
  logic [39:0] out_logb_data;
  logic [1:0]  out_loge_valid;
  logic        out_ready = 1'b1;
  logic        len_err;

  int n_checks = 0;
  int n_err    = 0;

`ifdef RR_UNPACK_LEN_CHECK_EN
  localparam logic c_LEN_ERR_EXP = 1'b1;
`else
  localparam logic c_LEN_ERR_EXP = 1'b0;
`endif

  rr_replay_bus_pack2unpack dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_len         (in_len),
    .in_logb_valid  (in_logb_valid),
    .in_loge_valid  (in_loge_valid),
    .in_ready       (in_ready),
    .out_valid      (out_valid),
    .out_logb_valid (out_logb_valid),
    .out_logb_data  (out_logb_data),
    .out_loge_valid (out_loge_valid),
    .out_ready      (out_ready),
    .len_err        (len_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one beat for a single edge; returns just after that edge.
  task automatic send(input logic [39:0] d, input logic [5:0] l,
                      input logic [3:0] bv, input logic [1:0] ev);
    in_data       = d;
    in_len        = l;
    in_logb_valid = bv;
    in_loge_valid = ev;
    in_valid      = 1'b1;
    #1;
    chk("send_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  function automatic logic [39:0] bp_beat(input int k);
    logic [3:0] nib;
    nib = 4'(k + 1);
    return {10{nib}};
  endfunction

  initial begin
    int sent;
    int got;
    int held;
    bit seen_ready;

    // Reset state
    repeat (3) step();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_data", 64'(out_logb_data), 64'd0);
    chk("rst_logb_valid", 64'(out_logb_valid), 64'd0);
    chk("rst_len_err", 64'(len_err), 64'd0);
    rst = 1'b0;
    step();
    chk("post_rst_ready", 64'(in_ready), 64'd1);

    // Full beat, 2-cycle latency
    send(40'hDEF71234A5, 6'd40, 4'b1111, 2'b10);
    chk("full_lat1_valid", 64'(out_valid), 64'd0);
    step();
    chk("full_valid", 64'(out_valid), 64'd1);
    chk("full_data", 64'(out_logb_data), 64'h00DEF71234A5);
    chk("full_logb_valid", 64'(out_logb_valid), 64'hF);
    chk("full_loge_valid", 64'(out_loge_valid), 64'h2);
    step();
    chk("full_no_dup", 64'(out_valid), 64'd0);

    // Sparse beat: channels 1 and 3, garbage above len
    send(40'hFFFABCBEEF, 6'd28, 4'b1010, 2'b00);
    step();
    chk("sparse_valid", 64'(out_valid), 64'd1);
    chk("sparse_data", 64'(out_logb_data), 64'h00ABC0BEEF00);
    chk("sparse_logb_valid", 64'(out_logb_valid), 64'hA);

    // Channels 0 and 2
    send(40'h555555593C, 6'd12, 4'b0101, 2'b00);
    step();
    chk("ch02_data", 64'(out_logb_data), 64'h000900003C);

    // Channel 3 only (lands in the top slot)
    send(40'hFFFFFFF5A5, 6'd12, 4'b1000, 2'b11);
    step();
    chk("ch3_data", 64'(out_logb_data), 64'h5A50000000);
    chk("ch3_loge", 64'(out_loge_valid), 64'h3);

    // Empty logb beat still forwarded
    send(40'hFFFFFFFFFF, 6'd0, 4'b0000, 2'b01);
    step();
    chk("empty_valid", 64'(out_valid), 64'd1);
    chk("empty_loge", 64'(out_loge_valid), 64'h1);
    chk("empty_data", 64'(out_logb_data), 64'd0);
    chk("good_len_err", 64'(len_err), 64'd0);
    step();

    // Backpressure: 6 beats, out_ready low for cycles 3..7
    sent = 0;
    got  = 0;
    held = -1;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      bit acc;
      out_ready     = !(cyc >= 3 && cyc <= 7);
      in_valid      = (sent < 6);
      in_data       = bp_beat(sent);
      in_len        = 6'd40;
      in_logb_valid = 4'b1111;
      in_loge_valid = 2'b00;
      #1;
      acc = in_valid && in_ready;
      if (!in_ready && held < 0) held = sent - got;
      if (out_valid && out_ready) begin
        chk("bp_order", 64'(out_logb_data), 64'(bp_beat(got)));
        got++;
      end
      @(posedge clk);
      #1;
      if (acc) sent++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("bp_held_beats", 64'(held), 64'd2);
    chk("bp_sent", 64'(sent), 64'd6);
    chk("bp_got", 64'(got), 64'd6);
    step();
    chk("bp_drained", 64'(out_valid), 64'd0);

    // Length mismatch on an accepted beat
    send(40'h0000ABCBEEF, 6'd27, 4'b1010, 2'b00);
    chk("len_err_set", 64'(len_err), 64'(c_LEN_ERR_EXP));
    send(40'hDEF71234A5, 6'd40, 4'b1111, 2'b00);
    step();
    chk("len_err_sticky", 64'(len_err), 64'(c_LEN_ERR_EXP));
    chk("len_err_data_fwd", 64'(out_logb_data), 64'h00DEF71234A5);
    step();

    // Async reset with two beats in flight
    send(40'h1111111111, 6'd40, 4'b1111, 2'b00);
    send(40'h2222222222, 6'd40, 4'b1111, 2'b00);
    chk("inflight_valid", 64'(out_valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd0);
    chk("arst_len_err", 64'(len_err), 64'd0);
    chk("arst_data", 64'(out_logb_data), 64'd0);
    step();
    step();
    rst = 1'b0;
    seen_ready = 1'b0;
    for (int k = 0; k < 5 && !seen_ready; k++) begin
      step();
      seen_ready = in_ready;
    end
    chk("rel_ready_timeout", 64'(seen_ready), 64'd1);
    send(40'h3C3C3C3C3C, 6'd40, 4'b1111, 2'b01);
    chk("rel_no_stale", 64'(out_valid), 64'd0);
    step();
    chk("rel_valid", 64'(out_valid), 64'd1);
    chk("rel_data", 64'(out_logb_data), 64'h3C3C3C3C3C);
    chk("rel_loge", 64'(out_loge_valid), 64'h1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
